// File: rtl/ltc2308_pkg.sv
// Shared types and constants for the LTC2308 scan controller.
package ltc2308_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StXfer,
    StGap
  } state_e;

  localparam int unsigned DATA_W     = 12;
  localparam int unsigned CFG_W      = 6;
  localparam int unsigned XFER_BITS  = 12;
  localparam int unsigned GAP_CYCLES = 2;

  // Config word bit positions; bit 5 is shifted out first.
  localparam int unsigned CFG_SD_BIT  = 5;
  localparam int unsigned CFG_OS_BIT  = 4;
  localparam int unsigned CFG_S1_BIT  = 3;
  localparam int unsigned CFG_S0_BIT  = 2;
  localparam int unsigned CFG_UNI_BIT = 1;
  localparam int unsigned CFG_SLP_BIT = 0;

  // Single-ended config word for a channel.
  function automatic logic [CFG_W-1:0] ch_to_cfg(input logic [2:0] ch, input logic uni);
    logic [CFG_W-1:0] cfg;
    cfg              = '0;
    cfg[CFG_SD_BIT]  = 1'b1;
    cfg[CFG_OS_BIT]  = ch[0];
    cfg[CFG_S1_BIT]  = ch[2];
    cfg[CFG_S0_BIT]  = ch[1];
    cfg[CFG_UNI_BIT] = uni;
    cfg[CFG_SLP_BIT] = 1'b0;
    return cfg;
  endfunction

endpackage

// File: rtl/ltc2308_sck_gen.sv
// SCK divider: CLK_DIV cycles low then CLK_DIV cycles high, XFER_BITS periods per enable.
// rise_o marks the first high cycle, fall_o the last high cycle of a period,
// done_o the last high cycle of the final period.
module ltc2308_sck_gen
  import ltc2308_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o,
  output logic done_o
);

  localparam int unsigned     DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax  = DivW'(CLK_DIV - 1);
  localparam logic [3:0]      LastPer = 4'(XFER_BITS - 1);

  logic            phase_q;
  logic [DivW-1:0] div_q;
  logic [3:0]      per_q;

  // Phase/divider/period counters; held at zero while disabled so SCK idles low.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      phase_q <= 1'b0;
      div_q   <= '0;
      per_q   <= '0;
    end else if (!en_i) begin
      phase_q <= 1'b0;
      div_q   <= '0;
      per_q   <= '0;
    end else if (div_q == DivMax) begin
      div_q   <= '0;
      phase_q <= ~phase_q;
      if (phase_q) per_q <= per_q + 4'd1;
    end else begin
      div_q <= div_q + 1'b1;
    end
  end

  // Strobes decoded from the counter state.
  always_comb begin
    sck_o  = phase_q;
    rise_o = en_i & phase_q & (div_q == '0);
    fall_o = en_i & phase_q & (div_q == DivMax);
    done_o = fall_o & (per_q == LastPer);
  end

endmodule

// File: rtl/ltc2308_scan_ctrl.sv
// LTC2308 multi-channel scan sequencer: CONVST/SCK/SDI generation, one-frame result
// pipeline handling, tagged sample output and per-channel latest-value bank.
// Optional build macro LTC2308_AVG4_EN: four frames per channel, averaged result.
module ltc2308_scan_ctrl
  import ltc2308_pkg::*;
#(
  parameter int unsigned NUM_CH      = 8,
  parameter int unsigned CLK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 80,
  parameter int unsigned UNIPOLAR    = 1
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  input  logic                 iSTART,
  input  logic                 iCONT,
  output logic                 oBUSY,
  output logic                 oVALID,
  output logic [11:0]          oDATA,
  output logic [2:0]           oCH,
  output logic                 oSWEEP_DONE,
  output logic [NUM_CH*12-1:0] oCH_DATA,
  output logic                 oADC_CONVST,
  output logic                 oADC_SCK,
  output logic                 oADC_SDI,
  input  logic                 iADC_SDO
);

  localparam int unsigned     CntW    = (CONV_CYCLES > 1) ? $clog2(CONV_CYCLES) : 1;
  localparam logic [CntW-1:0] ConvMax = CntW'(CONV_CYCLES - 1);
  localparam logic            GapMax  = 1'(GAP_CYCLES - 1);
  localparam logic [2:0]      LastCh  = 3'(NUM_CH - 1);
  localparam logic            Uni     = (UNIPOLAR != 0);

  state_e              state_q;
  logic                busy_q;
  logic                convst_q;
  logic                sdi_q;
  logic [CFG_W-1:0]    cfg_sr_q;
  logic [CntW-1:0]     conv_cnt_q;
  logic                gap_cnt_q;
  logic [DATA_W-1:0]   shift_q;
  logic [2:0]          cfg_ch_q;   // channel configured in the current frame
  logic [2:0]          res_ch_q;   // channel whose result arrives in the current frame
  logic                prime_q;
  logic                sweep_end_q;
  logic                valid_q;
  logic [DATA_W-1:0]   data_q;
  logic [2:0]          ch_q;
  logic                sweep_pulse_q;
  logic [NUM_CH*12-1:0] ch_data_q;

  logic                sck_rise;
  logic                sck_fall;
  logic                sck_done;
  logic [CFG_W-1:0]    cfg_word;
  logic [DATA_W-1:0]   shift_nxt;
  logic [2:0]          next_ch;
  logic                emit;
  logic [DATA_W-1:0]   sample;

`ifdef LTC2308_AVG4_EN
  logic [1:0]          cfg_rep_q;
  logic [1:0]          res_rep_q;
  logic [DATA_W+1:0]   acc_q;
  logic [DATA_W+1:0]   acc_nxt;
`endif

  ltc2308_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i  (iCLK),
    .rst_ni (iRST_N),
    .en_i   (state_q == StXfer),
    .sck_o  (oADC_SCK),
    .rise_o (sck_rise),
    .fall_o (sck_fall),
    .done_o (sck_done)
  );

  // Frame-level combinational helpers; the last SDO bit may land on the done cycle.
  always_comb begin
    cfg_word  = ch_to_cfg(cfg_ch_q, Uni);
    shift_nxt = sck_rise ? {shift_q[DATA_W-2:0], iADC_SDO} : shift_q;
    next_ch   = (cfg_ch_q == LastCh) ? 3'd0 : cfg_ch_q + 3'd1;
`ifdef LTC2308_AVG4_EN
    acc_nxt   = ((res_rep_q == 2'd0) ? '0 : acc_q) + {2'b00, shift_nxt};
    emit      = !prime_q && (res_rep_q == 2'd3);
    sample    = acc_nxt[DATA_W+1:2];
`else
    emit      = !prime_q;
    sample    = shift_nxt;
`endif
  end

  // Sequencer FSM with registered pin and result outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q       <= StIdle;
      busy_q        <= 1'b0;
      convst_q      <= 1'b0;
      sdi_q         <= 1'b0;
      cfg_sr_q      <= '0;
      conv_cnt_q    <= '0;
      gap_cnt_q     <= 1'b0;
      shift_q       <= '0;
      cfg_ch_q      <= '0;
      res_ch_q      <= '0;
      prime_q       <= 1'b1;
      sweep_end_q   <= 1'b0;
      valid_q       <= 1'b0;
      data_q        <= '0;
      ch_q          <= '0;
      sweep_pulse_q <= 1'b0;
      ch_data_q     <= '0;
`ifdef LTC2308_AVG4_EN
      cfg_rep_q     <= '0;
      res_rep_q     <= '0;
      acc_q         <= '0;
`endif
    end else begin
      valid_q       <= 1'b0;
      sweep_pulse_q <= 1'b0;
      if (sck_rise) shift_q <= shift_nxt;

      unique case (state_q)
        StIdle: begin
          if (iSTART || iCONT) begin
            state_q    <= StConv;
            busy_q     <= 1'b1;
            convst_q   <= 1'b1;
            conv_cnt_q <= '0;
          end
        end

        StConv: begin
          if (conv_cnt_q == ConvMax) begin
            state_q  <= StXfer;
            convst_q <= 1'b0;
            cfg_sr_q <= cfg_word;
            sdi_q    <= cfg_word[CFG_W-1];
          end else begin
            conv_cnt_q <= conv_cnt_q + 1'b1;
          end
        end

        StXfer: begin
          // Next SDI bit is set up on the last high cycle so it is stable for the low phase.
          if (sck_fall) begin
            cfg_sr_q <= {cfg_sr_q[CFG_W-2:0], 1'b0};
            sdi_q    <= cfg_sr_q[CFG_W-2];
          end
          if (sck_done) begin
            state_q   <= StGap;
            gap_cnt_q <= 1'b0;
            sdi_q     <= 1'b0;
            if (emit) begin
              valid_q <= 1'b1;
              data_q  <= sample;
              ch_q    <= res_ch_q;
              for (int unsigned k = 0; k < NUM_CH; k++) begin
                if (res_ch_q == 3'(k)) ch_data_q[k*12 +: 12] <= sample;
              end
            end
            sweep_pulse_q <= emit && (res_ch_q == LastCh);
            sweep_end_q   <= emit && (res_ch_q == LastCh);
            res_ch_q      <= cfg_ch_q;
            prime_q       <= 1'b0;
`ifdef LTC2308_AVG4_EN
            if (!prime_q) acc_q <= acc_nxt;
            res_rep_q <= cfg_rep_q;
            if (cfg_rep_q == 2'd3) begin
              cfg_rep_q <= '0;
              cfg_ch_q  <= next_ch;
            end else begin
              cfg_rep_q <= cfg_rep_q + 2'd1;
            end
`else
            cfg_ch_q <= next_ch;
`endif
          end
        end

        StGap: begin
          if (gap_cnt_q == GapMax) begin
            if (sweep_end_q && !iCONT) begin
              state_q  <= StIdle;
              busy_q   <= 1'b0;
              prime_q  <= 1'b1;
              cfg_ch_q <= '0;
`ifdef LTC2308_AVG4_EN
              cfg_rep_q <= '0;
`endif
            end else begin
              state_q    <= StConv;
              convst_q   <= 1'b1;
              conv_cnt_q <= '0;
            end
          end else begin
            gap_cnt_q <= gap_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    oBUSY       = busy_q;
    oVALID      = valid_q;
    oDATA       = data_q;
    oCH         = ch_q;
    oSWEEP_DONE = sweep_pulse_q;
    oCH_DATA    = ch_data_q;
    oADC_CONVST = convst_q;
    oADC_SDI    = sdi_q;
  end

endmodule

// File: tb/tb_ltc2308_scan_ctrl.sv
// Self-checking bench for ltc2308_scan_ctrl with a behavioural LTC2308 model and scoreboard.
module tb_ltc2308_scan_ctrl;

  localparam int unsigned NUM_CH      = 8;
  localparam int unsigned CLK_DIV     = 2;
  localparam int unsigned CONV_CYCLES = 80;
  localparam int          CLK_PER     = 10;
`ifdef LTC2308_AVG4_EN
  localparam int REPS = 4;
`else
  localparam int REPS = 1;
`endif
  localparam int FRAMES_PER_SWEEP = NUM_CH * REPS;
  localparam int BUDGET           = 20000;

  logic                 iCLK   = 1'b0;
  logic                 iRST_N = 1'b0;
  logic                 iSTART = 1'b0;
  logic                 iCONT  = 1'b0;
  logic                 oBUSY, oVALID, oSWEEP_DONE;
  logic [11:0]          oDATA;
  logic [2:0]           oCH;
  logic [NUM_CH*12-1:0] oCH_DATA;
  logic                 oADC_CONVST, oADC_SCK, oADC_SDI;
  logic                 adc_sdo;

  ltc2308_scan_ctrl #(
    .NUM_CH      (NUM_CH),
    .CLK_DIV     (CLK_DIV),
    .CONV_CYCLES (CONV_CYCLES),
    .UNIPOLAR    (1)
  ) dut (
    .iCLK        (iCLK),
    .iRST_N      (iRST_N),
    .iSTART      (iSTART),
    .iCONT       (iCONT),
    .oBUSY       (oBUSY),
    .oVALID      (oVALID),
    .oDATA       (oDATA),
    .oCH         (oCH),
    .oSWEEP_DONE (oSWEEP_DONE),
    .oCH_DATA    (oCH_DATA),
    .oADC_CONVST (oADC_CONVST),
    .oADC_SCK    (oADC_SCK),
    .oADC_SDI    (oADC_SDI),
    .iADC_SDO    (adc_sdo)
  );

  always #(CLK_PER / 2) iCLK = ~iCLK;

  int total = 0;
  int bad   = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected config words for ch0..7, MSB first.
  logic [5:0] cfg_tbl [8] = '{6'b100010, 6'b110010, 6'b100110, 6'b110110,
                              6'b101010, 6'b111010, 6'b101110, 6'b111110};

  typedef struct packed {
    logic [2:0]  ch;
    logic [11:0] data;
  } exp_t;

  exp_t       exp_q [$];
  logic [5:0] cfg_q [$];
  exp_t       e;
  int         nvalid = 0;
  int         frames = 0;
  int         falls  = 0;
  int         rises_in_frame = 0;

  function automatic logic [11:0] exp_value(input int ch);
`ifdef LTC2308_AVG4_EN
    return 12'(11 + 16 * ch);
`else
    return 12'(256 + ch);
`endif
  endfunction

  function automatic logic [11:0] model_value(input int ch, input int rep);
`ifdef LTC2308_AVG4_EN
    return 12'(10 + 16 * ch + (rep % 4));
`else
    return 12'(256 + ch + 0 * rep);
`endif
  endfunction

  function automatic logic [2:0] decode(input logic [5:0] w);
    return {w[3], w[2], w[4]};
  endfunction

  // Expected SDI words and samples for a run of whole sweeps started from idle.
  task automatic push_run(input int sweeps);
    for (int f = 0; f < sweeps * FRAMES_PER_SWEEP + 1; f++)
      cfg_q.push_back(cfg_tbl[(f / REPS) % NUM_CH]);
    for (int s = 0; s < sweeps; s++)
      for (int c = 0; c < int'(NUM_CH); c++)
        exp_q.push_back(exp_t'{3'(c), exp_value(c)});
  endtask

  // ADC model: returns the result of the previous frame's config word.
  logic [11:0] adc_sr = '0;
  logic [5:0]  sdi_word = '0;
  logic [5:0]  last_word = 6'b100010;
  int          sdi_bits = 0;
  int          rep = 0;
  logic [2:0]  last_conv_ch = '0;
  logic [2:0]  conv_ch;
  longint      conv_rise_t = -1;
  longint      frame_rise_t = -1;
  longint      sck_rise_t = -1;

  assign adc_sdo = adc_sr[11];

  always @(posedge oADC_CONVST) begin
    sdi_bits       = 0;
    rises_in_frame = 0;
    sck_rise_t     = -1;
    frames++;
    if (frame_rise_t >= 0) check_eq("frame_period", 128'($time - frame_rise_t), 130 * CLK_PER);
    frame_rise_t = longint'($time);
    conv_rise_t  = longint'($time);
  end

  always @(negedge oADC_CONVST) begin
    if (iRST_N) begin
      falls++;
      if (conv_rise_t >= 0)
        check_eq("convst_high", 128'($time - conv_rise_t), CONV_CYCLES * CLK_PER);
      conv_ch = decode(last_word);
      if (conv_ch == last_conv_ch) rep++;
      else rep = 0;
      last_conv_ch = conv_ch;
      adc_sr = model_value(int'(conv_ch), rep);
    end
  end

  always @(negedge oADC_SCK) adc_sr = {adc_sr[10:0], 1'b0};

  always @(posedge oADC_SCK) begin
    rises_in_frame++;
    if (sck_rise_t >= 0) check_eq("sck_period", 128'($time - sck_rise_t), 2 * CLK_DIV * CLK_PER);
    sck_rise_t = longint'($time);
    if (sdi_bits < 6) begin
      sdi_word = {sdi_word[4:0], oADC_SDI};
      sdi_bits++;
      if (sdi_bits == 6) begin
        last_word = sdi_word;
        if (cfg_q.size() == 0) check_eq("sdi_extra", sdi_word, 6'd0);
        else check_eq("sdi_word", sdi_word, cfg_q.pop_front());
      end
    end
  end

  always @(negedge oBUSY) frame_rise_t = -1;
  always @(negedge iRST_N) begin
    frame_rise_t = -1;
    sck_rise_t   = -1;
    conv_rise_t  = -1;
  end

  // Output monitor: pops the scoreboard on each oVALID.
  always @(negedge iCLK) begin
    if (iRST_N && oVALID) begin
      if (exp_q.size() == 0) begin
        check_eq("valid_unexpected", oVALID, 1'b0);
      end else begin
        e = exp_q.pop_front();
        check_eq("ch", oCH, e.ch);
        check_eq("data", oDATA, e.data);
        check_eq("sweep_done", oSWEEP_DONE, e.ch == 3'(NUM_CH - 1));
        check_eq("ch_data_slot", oCH_DATA[int'(e.ch) * 12 +: 12], e.data);
        nvalid++;
      end
    end else if (iRST_N && oSWEEP_DONE) begin
      check_eq("sweep_done_alone", oSWEEP_DONE, 1'b0);
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_busy"}, oBUSY, 0);
    check_eq({tag, "_valid"}, oVALID, 0);
    check_eq({tag, "_data"}, oDATA, 0);
    check_eq({tag, "_ch"}, oCH, 0);
    check_eq({tag, "_sweep_done"}, oSWEEP_DONE, 0);
    check_eq({tag, "_ch_data"}, oCH_DATA, 0);
    check_eq({tag, "_convst"}, oADC_CONVST, 0);
    check_eq({tag, "_sck"}, oADC_SCK, 0);
    check_eq({tag, "_sdi"}, oADC_SDI, 0);
  endtask

  task automatic pulse_start();
    iSTART = 1'b1;
    @(negedge iCLK);
    iSTART = 1'b0;
  endtask

  // Waits for the final sample of a sweep, then checks oBUSY drops two cycles later.
  task automatic wait_sweep_end(input string tag);
    int n = 0;
    while (!(oVALID && oSWEEP_DONE) && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= BUDGET) begin
      check_eq({tag, "_timeout"}, oSWEEP_DONE, 1'b1);
    end else begin
      @(negedge iCLK);
      check_eq({tag, "_busy_gap"}, oBUSY, 1'b1);
      @(negedge iCLK);
      check_eq({tag, "_busy_idle"}, oBUSY, 1'b0);
    end
  endtask

  task automatic check_run_end(input string tag, input int sweeps);
    check_eq({tag, "_frames"}, frames, sweeps * FRAMES_PER_SWEEP + 1);
    check_eq({tag, "_nvalid"}, nvalid, sweeps * NUM_CH);
    check_eq({tag, "_exp_left"}, exp_q.size(), 0);
    check_eq({tag, "_cfg_left"}, cfg_q.size(), 0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge iCLK);
    check_all_zero("reset");
    iRST_N = 1'b1;
    @(negedge iCLK);

    // Single sweep; a second start while busy must be ignored.
    frames = 0;
    nvalid = 0;
    push_run(1);
    pulse_start();
    check_eq("busy_after_start", oBUSY, 1'b1);
    repeat (200) @(negedge iCLK);
    pulse_start();
    wait_sweep_end("single");
    repeat (20) @(negedge iCLK);
    check_run_end("single", 1);
    for (int c = 0; c < int'(NUM_CH); c++)
      check_eq("bank", oCH_DATA[c * 12 +: 12], exp_value(c));

    // Continuous for about 2.5 sweeps, then drop iCONT: three full sweeps.
    frames = 0;
    nvalid = 0;
    push_run(3);
    iCONT = 1'b1;
    n = 0;
    while (nvalid < 5 * NUM_CH / 2 && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= BUDGET) check_eq("cont_timeout", nvalid, 5 * NUM_CH / 2);
    iCONT = 1'b0;
    wait_sweep_end("cont");
    repeat (20) @(negedge iCLK);
    check_run_end("cont", 3);

    // Reset mid-XFER, then restart with a fresh priming frame.
    frames = 0;
    nvalid = 0;
    falls  = 0;
    push_run(1);
    pulse_start();
    n = 0;
    while (!(falls >= 2 && rises_in_frame >= 8) && n < BUDGET) begin
      @(negedge iCLK);
      n++;
    end
    if (n >= BUDGET) check_eq("xfer_timeout", falls, 2);
    #2;
    iRST_N = 1'b0;
    #1;
    check_all_zero("mid_reset");
    exp_q.delete();
    cfg_q.delete();
    @(negedge iCLK);
    iRST_N = 1'b1;
    @(negedge iCLK);
    frames = 0;
    nvalid = 0;
    push_run(1);
    pulse_start();
    wait_sweep_end("restart");
    repeat (20) @(negedge iCLK);
    check_run_end("restart", 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
